fetch_phase_unit: RTL and testbench
===================================

Name: fetch_phase_unit

Overview:
- Fetch stage directly upstream of the unified single-ported instruction/data memory.
- Owns the PC and generates the sclk phase signal: sclk=1 selects instruction fetch, sclk=0 selects data access.
- Multiplexes the memory address between PC and the data address from the execute stage.
- Registers the fetched instruction and its PC for decode. Handles stall, branch/jump redirect and ecall/ebreak halt.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000033, instruction presented on if_inst after reset or squash (add x0,x0,x0).
- ADDR_W, 8, width of the memory address port.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- sclk  out  1  memory phase select: 1 = fetch, 0 = data access.
- mem_addr  out  ADDR_W  memory address: pc[ADDR_W+1:2] when sclk=1, data_addr when sclk=0.
- mem_inst  in  32  memory read data (valid as an instruction while sclk=1).
- data_addr  in  ADDR_W  load/store byte address from the execute stage.
- stall  in  1  hold the PC and the fetch register for this fetch slot.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  target PC for the redirect.
- halt  in  1  ecall/ebreak decoded.
- if_inst  out  32  registered instruction for decode.
- if_pc  out  32  PC of if_inst.
- if_valid  out  1  if_inst is a real, unsquashed instruction.
- halted  out  1  unit is stopped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst has priority over everything.
- Reset values: pc=RESET_PC, state=FETCH, sclk=1, if_inst=NOP_INST, if_pc=0, if_valid=0, halted=0.
- Reset mid-operation: same values on the next edge; any in-flight redirect or halt is discarded.
- FSM states:
  - FETCH: sclk=1, mem_addr=pc[ADDR_W+1:2].
  - DATA: sclk=0, mem_addr=data_addr.
  - HALTED: sclk=0, mem_addr=data_addr, halted=1, if_valid=0.
- sclk is decoded from the state register (glitch-free); it is not derived combinationally from inputs.
- Per-edge priority: rst > halt > redirect > stall > normal.
- FETCH edge:
  - halt → HALTED.
  - redirect → pc<=redirect_pc; if_inst<=NOP_INST; if_valid<=0; → DATA.
  - stall → pc, if_inst, if_pc and if_valid held; → DATA.
  - otherwise → if_inst<=mem_inst; if_pc<=pc; if_valid<=1; pc<=pc+4; → DATA.
- DATA edge:
  - halt → HALTED.
  - redirect → pc<=redirect_pc; if_inst<=NOP_INST; if_valid<=0; → FETCH.
  - otherwise → FETCH; stall is ignored in DATA.
- HALTED: all registers frozen; exit only via rst.
- Throughput and latency: one instruction per 2 clks. if_inst/if_pc update on the FETCH→DATA edge and stay stable until the next FETCH→DATA edge.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. mem_addr takes the PC word index with no bounds check.
- Simultaneous redirect and stall: redirect wins, and the fetch slot is squashed.
- Simultaneous halt and redirect: halt wins, and the pc is not updated.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 enters HALTED and sets an extra output fetch_misalign=1 (reset 0, sticky until rst). pc is loaded with the offending redirect_pc for debug.
- Undefined: redirect_pc[1:0] is forced to 2'b00 on load, and the fetch_misalign port does not exist.

Test Plan:
- Reset then run 6 clks with mem_inst=32'h00A00093 → sclk sequence 1,0,1,0,1,0; if_pc=0,0,4,4,8,8 after edges 1-6; if_valid=1 from edge 1.
- stall=1 during the second FETCH cycle → pc stays 4; if_pc remains 0 through edge 4; mem_addr=1 again at the next FETCH.
- redirect=1, redirect_pc=32'h40 in a DATA cycle → next FETCH has mem_addr=8'h10 (0x40>>2); if_valid=0 and if_inst=32'h00000033 until the following capture.
- data_addr=8'h0C in DATA cycles → mem_addr=8'h0C exactly when sclk=0, and pc[9:2] when sclk=1.
- halt=1 together with redirect=1 → halted=1, sclk=0, pc unchanged, if_valid=0 for 10 further clks; rst=1 for one cycle restores pc=0 and sclk=1.
- With FETCH_MISALIGN_TRAP_EN defined: redirect_pc=32'h42 → fetch_misalign=1 and halted=1. With it undefined: pc=32'h40 and the fetch proceeds.

Source files
------------

// File: rtl/fetch_phase_unit.sv
// ============================================================================
//  Module      : fetch_phase_unit
//  Description : Fetch stage in front of a unified single-ported memory.
//                Owns the PC and drives sclk, which alternates the memory
//                between instruction fetch (sclk=1) and data access
//                (sclk=0). It muxes the memory address, registers the
//                fetched instruction and its PC for decode, and handles
//                stall, redirect and halt.
//                Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a
//                target that is not word-aligned halts the unit and raises
//                the sticky fetch_misalign output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_phase_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0033,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sclk,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_inst,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    output logic              if_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              fetch_misalign,
`endif
    output logic              halted
);

    // Memory phase state. Encoding 2'd3 is unused and recovers to FETCH.
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DATA   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_if_inst_nxt;
    logic [31:0] w_if_pc_nxt;
    logic        w_if_valid_nxt;

    // Redirect target and whether it must trap instead of being followed.
    logic [31:0] w_redir_target;
    logic        w_redir_trap;
    logic        w_misalign_nxt;
    logic        r_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
    // The offending target is kept intact in the PC so it can be inspected.
    assign w_redir_target = redirect_pc;
    assign w_redir_trap   = (redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are discarded: the PC is always word-aligned.
    logic [1:0] w_unused_redir_lsbs;
    assign w_unused_redir_lsbs = redirect_pc[1:0];
    assign w_redir_target      = {redirect_pc[31:2], 2'b00};
    assign w_redir_trap        = 1'b0;
`endif

    // Next-state and next-register computation; priority halt > redirect > stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_inst_nxt  = r_if_inst;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        w_misalign_nxt = r_misalign;

        case (r_state)
            S_FETCH: begin
                if (halt) begin
                    // Halt wins over a same-cycle redirect; PC is not touched.
                    w_state_nxt = S_HALTED;
                end else if (redirect) begin
                    // Redirect also wins over stall: the fetch slot is squashed.
                    w_pc_nxt       = w_redir_target;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                    if (w_redir_trap) begin
                        w_state_nxt    = S_HALTED;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else if (stall) begin
                    // Hold the fetch register and PC, but still give the
                    // data phase its slot.
                    w_state_nxt = S_DATA;
                end else begin
                    w_if_inst_nxt  = mem_inst;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + 32'd4;
                    w_state_nxt    = S_DATA;
                end
            end

            S_DATA: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (redirect) begin
                    w_pc_nxt       = w_redir_target;
                    w_if_inst_nxt  = NOP_INST;
                    w_if_valid_nxt = 1'b0;
                    if (w_redir_trap) begin
                        w_state_nxt    = S_HALTED;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    // Stall only affects the fetch slot, so DATA always advances.
                    w_state_nxt = S_FETCH;
                end
            end

            S_HALTED: begin
                // Everything frozen; only reset leaves this state.
                w_state_nxt = S_HALTED;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC and fetch register for decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= 32'h0000_0000;
            r_if_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    // Sticky misaligned-redirect flag (constant 0 when the trap is not built).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = r_misalign;
`endif

    // sclk is a pure decode of the state register, so it cannot glitch on inputs.
    assign sclk     = (r_state == S_FETCH);
    assign halted   = (r_state == S_HALTED);
    assign mem_addr = sclk ? r_pc[ADDR_W+1:2] : data_addr;
    assign if_inst  = r_if_inst;
    assign if_pc    = r_if_pc;
    // A halted unit never presents a valid instruction, whatever was held.
    assign if_valid = r_if_valid & ~halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_phase_unit.sv
// ============================================================================
//  Module      : tb_fetch_phase_unit
//  Description : Directed self-checking bench for fetch_phase_unit.
//                Honors FETCH_MISALIGN_TRAP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_phase_unit;

    localparam logic [31:0] C_NOP  = 32'h0000_0033;
    localparam logic [31:0] C_INST = 32'h00A0_0093;
    localparam logic [31:0] C_ALT  = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic [7:0]  mem_addr;
    logic [31:0] mem_inst;
    logic [7:0]  data_addr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_phase_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (C_NOP),
        .ADDR_W   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .data_addr      (data_addr),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
`endif
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        mem_inst    = C_INST;
        data_addr   = 8'h00;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        #1;
        step();

        // ---------------- reset values and basic fetch cadence ----------------
        do_reset();
        check("rst_sclk",     32'(sclk),     32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_if_inst",  if_inst,       C_NOP);
        check("rst_if_pc",    if_pc,         32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_halted",   32'(halted),   32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("run_sclk_e%0d", k),  32'(sclk),     32'((k % 2) == 0));
            check($sformatf("run_ifpc_e%0d", k),  if_pc,         32'(((k - 1) / 2) * 4));
            check($sformatf("run_valid_e%0d", k), 32'(if_valid), 32'd1);
            if ((k % 2) == 0)
                check($sformatf("run_maddr_e%0d", k), 32'(mem_addr), 32'(k / 2));
        end
        check("run_if_inst", if_inst, C_INST);

        // ---------------- stall, data address mux, redirect ----------------
        do_reset();
        data_addr = 8'h0C;
        step();                                   // e1: capture pc 0 -> DATA
        check("mux_data_addr", 32'(mem_addr), 32'h0C);
        step();                                   // e2: FETCH at pc 4
        check("mux_fetch_addr", 32'(mem_addr), 32'd1);
        stall = 1'b1;
        step();                                   // e3: stalled fetch -> DATA
        stall = 1'b0;
        check("stall_if_pc",  if_pc,          32'd0);
        check("stall_sclk",   32'(sclk),      32'd0);
        check("stall_data",   32'(mem_addr),  32'h0C);
        step();                                   // e4: FETCH again, pc still 4
        check("stall_refetch_sclk", 32'(sclk),     32'd1);
        check("stall_refetch_addr", 32'(mem_addr), 32'd1);
        check("stall_if_pc_e4",     if_pc,         32'd0);
        mem_inst = C_ALT;
        step();                                   // e5: capture pc 4
        check("post_stall_if_pc",   if_pc,   32'd4);
        check("post_stall_if_inst", if_inst, C_ALT);

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();                                   // e6: redirect in DATA
        redirect = 1'b0;
        check("redir_sclk",    32'(sclk),     32'd1);
        check("redir_addr",    32'(mem_addr), 32'h10);
        check("redir_valid",   32'(if_valid), 32'd0);
        check("redir_if_inst", if_inst,       C_NOP);
        step();                                   // e7: capture target
        check("redir_cap_pc",    if_pc,         32'h40);
        check("redir_cap_valid", 32'(if_valid), 32'd1);
        check("redir_cap_inst",  if_inst,       C_ALT);
        step();                                   // e8: FETCH at 0x44
        check("redir_next_addr", 32'(mem_addr), 32'h11);

        // redirect and stall together in FETCH: redirect wins, slot squashed
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        check("rs_valid", 32'(if_valid), 32'd0);
        check("rs_inst",  if_inst,       C_NOP);
        check("rs_sclk",  32'(sclk),     32'd0);
        step();
        check("rs_addr",  32'(mem_addr), 32'h20);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_squash", 32'(if_valid), 32'd0);
        step();
        check("wrap_addr_top", 32'(mem_addr), 32'hFF);
        step();
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(if_valid), 32'd1);
        step();
        check("wrap_addr_zero", 32'(mem_addr), 32'h00);
        check("wrap_sclk",      32'(sclk),     32'd1);

        // misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_halted",   32'(halted),         32'd1);
        check("mis_flag",     32'(fetch_misalign), 32'd1);
        check("mis_sclk",     32'(sclk),           32'd0);
        step();
        check("mis_sticky",   32'(fetch_misalign), 32'd1);
        check("mis_stay",     32'(halted),         32'd1);
`else
        check("mis_halted", 32'(halted), 32'd0);
        check("mis_sclk",   32'(sclk),   32'd0);
        step();
        check("mis_addr",   32'(mem_addr), 32'h10);
        step();
        check("mis_if_pc",  if_pc,         32'h40);
        check("mis_valid",  32'(if_valid), 32'd1);
`endif

        // ---------------- halt together with redirect ----------------
        do_reset();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_cleared", 32'(fetch_misalign), 32'd0);
`endif
        step();                                   // capture pc 0
        step();                                   // FETCH at pc 4
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        step();
        halt     = 1'b0;
        redirect = 1'b0;
        check("halt_halted", 32'(halted),   32'd1);
        check("halt_sclk",   32'(sclk),     32'd0);
        check("halt_valid",  32'(if_valid), 32'd0);
        check("halt_addr",   32'(mem_addr), 32'h0C);
        mem_inst = C_INST;
        stall    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("halt_hold_h%0d", i),  32'(halted),   32'd1);
            check($sformatf("halt_hold_s%0d", i),  32'(sclk),     32'd0);
            check($sformatf("halt_hold_v%0d", i),  32'(if_valid), 32'd0);
            check($sformatf("halt_hold_pc%0d", i), if_pc,         32'd0);
        end
        do_reset();
        check("unhalt_sclk",   32'(sclk),     32'd1);
        check("unhalt_addr",   32'(mem_addr), 32'd0);
        check("unhalt_halted", 32'(halted),   32'd0);
        step();
        check("unhalt_if_pc",  if_pc,         32'd0);
        check("unhalt_valid",  32'(if_valid), 32'd1);
        step();
        check("unhalt_addr2",  32'(mem_addr), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
